// File: rtl/reg_bank_if.sv
// Register-file access bus: two combinational read ports and one write port.
// master = decode/write-back side, slave = the register bank.
interface reg_bank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ra1;
    logic [ADDR_WIDTH-1:0] ra2;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;

    modport master (
        output ra1, ra2, we, wa, wd,
        input  rd1, rd2
    );

    modport slave (
        input  ra1, ra2, we, wa, wd,
        output rd1, rd2
    );
endinterface

// File: rtl/reg_bank.sv
// MIPS GPR file: 2**ADDR_WIDTH x DATA_WIDTH, entry 0 reads as zero, async active-high clear.
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.
module reg_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;

    // Writes to $zero are dropped here, so entry 0 stays cleared after reset.
    assign wr_en = bus.we && (bus.wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // Read port 1; reset forces zero even if a bypass would otherwise apply.
    always_comb begin
        bus.rd1 = '0;
        if (!rst && (bus.ra1 != '0)) begin
            bus.rd1 = mem[bus.ra1];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.wa == bus.ra1)) begin
                bus.rd1 = bus.wd;
            end
`endif
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        bus.rd2 = '0;
        if (!rst && (bus.ra2 != '0)) begin
            bus.rd2 = mem[bus.ra2];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.wa == bus.ra2)) begin
                bus.rd2 = bus.wd;
            end
`endif
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// against an array-based model of the architectural register state.
module tb_reg_bank;
    logic clk;
    logic rst;

    reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Architectural view of a read at this instant.
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (BYPASS && bus.we && bus.wa == a) return bus.wd;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One rising edge with model update, returning at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && bus.we && bus.wa != 5'd0) model[bus.wa] = bus.wd;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.wa = a; bus.wd = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic check_ports(input string tag);
        check({tag, ".rd1"}, bus.rd1, expect_rd(bus.ra1));
        check({tag, ".rd2"}, bus.rd2, expect_rd(bus.ra2));
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        bus.ra1 = 5'd5; bus.ra2 = 5'd31;
        bus.we = 1'b0; bus.wa = 5'd0; bus.wd = 32'd0;
        #1;
        check("rst_rd1", bus.rd1, 32'd0);
        check("rst_rd2", bus.rd2, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous clear in mid-cycle, no clock edge involved.
        write_reg(5'd5, 32'hDEADBEEF);
        bus.ra1 = 5'd5;
        #1 check("pre_async_r5", bus.rd1, 32'hDEADBEEF);
        #1 rst = 1'b1;
        clear_model();
        #1 check("async_rst_r5", bus.rd1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.ra1 = 5'(a);
            bus.ra2 = 5'(31 - a);
            #1;
            check("post_rst_rd1", bus.rd1, 32'd0);
            check("post_rst_rd2", bus.rd2, 32'd0);
            @(negedge clk);
        end

        // Basic writes on consecutive edges.
        bus.we = 1'b1; bus.wa = 5'd1; bus.wd = 32'h00000011;
        tick();
        bus.wa = 5'd31; bus.wd = 32'hFFFFFFFF;
        tick();
        bus.we = 1'b0;
        bus.ra1 = 5'd1; bus.ra2 = 5'd31;
        #1;
        check("basic_r1", bus.rd1, 32'h00000011);
        check("basic_r31", bus.rd2, 32'hFFFFFFFF);
        bus.ra1 = 5'd31;
        #1;
        check("same_r31_p1", bus.rd1, 32'hFFFFFFFF);
        check("same_r31_p2", bus.rd2, 32'hFFFFFFFF);

        // $zero ignores writes, including the bypass path.
        bus.ra1 = 5'd0;
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'h12345678;
        #1 check("zero_pre_edge", bus.rd1, 32'd0);
        tick();
        check("zero_held_we", bus.rd1, 32'd0);
        bus.we = 1'b0;
        #1 check("zero_after", bus.rd1, 32'd0);

        // Same-cycle read of the write address.
        write_reg(5'd7, 32'hAAAA0000);
        bus.ra1 = 5'd7; bus.ra2 = 5'd7;
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h0000BBBB;
        #1;
        check("fwd_r7_p1", bus.rd1, BYPASS ? 32'h0000BBBB : 32'hAAAA0000);
        check("fwd_r7_p2", bus.rd2, BYPASS ? 32'h0000BBBB : 32'hAAAA0000);
        tick();
        bus.we = 1'b0;
        #1 check("r7_after_edge", bus.rd1, 32'h0000BBBB);

        // we=0 holds contents over several edges.
        write_reg(5'd3, 32'h00000003);
        bus.wa = 5'd3; bus.wd = 32'h99999999; bus.ra1 = 5'd3;
        for (int i = 0; i < 4; i++) tick();
        check("hold_r3", bus.rd1, 32'h00000003);

        // Reset rising on a write edge wins.
        write_reg(5'd9, 32'h00000077);
        bus.ra1 = 5'd9;
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h00000055;
        @(posedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b0;
        #1 check("collide_r9", bus.rd1, 32'd0);
        @(negedge clk);
        write_reg(5'd9, 32'h00000066);
        #1 check("post_rst_write_r9", bus.rd1, 32'h00000066);
        @(negedge clk);

        // Randomized traffic, read addresses biased toward the write address.
        for (int i = 0; i < 400; i++) begin
            bus.we  = 1'($urandom_range(0, 2) != 0);
            bus.wa  = 5'($urandom_range(0, 31));
            bus.wd  = $urandom();
            bus.ra1 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            bus.ra2 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            #1 check_ports("rand");
            tick();
        end

        // Final sweep of every register against the model.
        bus.we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.ra1 = 5'(a);
            bus.ra2 = 5'(a);
            #1 check_ports("sweep");
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
